i2s_frame_ctrl: RTL and testbench
=================================

# i2s_frame_ctrl

I2S master frame controller that generates the bit clock (`bck`) and channel select (`lrck`) for the I2S receive datapath from the local system clock. It sequences start and stop on stereo-frame boundaries. It also emits per-bit sample strobes, channel and word-boundary markers so the receiver's shift register and word assembly run in the `clk` domain without re-synchronising `bck`/`lrck`. It sits between the system control (`enable`) and the I2S receiver/pins.

## Interface
- `BCK_DIV`, 4: `clk` cycles per `bck` half-period; legal range ≥ 1.
- `SLOT_BITS`, 32: `bck` periods per channel slot.
- `WORD_BITS`, 24: data bits captured per slot; legal range 1 ≤ WORD_BITS ≤ SLOT_BITS-1.
- `clk`  in  1  local system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request, level-sensitive.
- `bck`  out  1  generated bit clock, registered.
- `lrck`  out  1  channel select, registered; 0 = left, 1 = right.
- `sample_en`  out  1  one-`clk` pulse on each `bck` rising edge that carries a data bit.
- `bit_cnt`  out  $clog2(SLOT_BITS)  current bit position in the slot.
- `ch`  out  1  channel of the current `sample_en`; equals `lrck`.
- `last_bit`  out  1  coincides with the `sample_en` for the LSB (bit_cnt == WORD_BITS).
- `frame_start`  out  1  one-`clk` pulse on the first `bck` rise of each left slot.
- `frame_cnt`  out  16  completed frames; wraps at 2^16.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- FSM states are IDLE, RUN and DRAIN.
- **IDLE**
  - `bck` = 0, `lrck` = 0, `bit_cnt` = 0, divider = 0, all pulses 0.
  - If `enable` = 1, go to RUN on the next cycle with the divider at 0.
- **Divider (RUN and DRAIN)**
  - `div_cnt` increments each cycle.
  - When `div_cnt` == BCK_DIV-1: `div_cnt` ← 0 and `bck` toggles.
- **Falling edge** (`bck` 1→0)
  - `bit_cnt` ← (`bit_cnt`+1) mod SLOT_BITS.
  - On wrap, `lrck` toggles.
  - `lrck` and `bit_cnt` change only on falling edges.
- **Rising edge** (`bck` 0→1)
  - Slot bit 0 is the I2S one-bit delay. It produces no `sample_en`.
  - `sample_en` = 1 when 1 ≤ `bit_cnt` ≤ WORD_BITS. `bit_cnt` = 1 is the MSB.
  - `last_bit` = 1 when `bit_cnt` == WORD_BITS.
  - `frame_start` = 1 when `lrck` = 0 and `bit_cnt` = 0.
  - Bits WORD_BITS+1 .. SLOT_BITS-1 are padding and produce no strobe.
- **Frame completion**
  - A frame completes on the falling edge where `bit_cnt` wraps while `lrck` = 1.
  - `frame_cnt` increments by 1 there, in both RUN and DRAIN.
- **RUN → DRAIN**: when `enable` = 0.
- **DRAIN**
  - Keeps generating clocks and strobes exactly as in RUN.
  - If `enable` returns to 1 before completion, go back to RUN with no glitch or phase change.
  - At frame completion, go to IDLE with `bck` = 0, `lrck` = 0, `bit_cnt` = 0, divider = 0.
- **Partial frames**
  - No partial frame is ever emitted after the first `bck` edge; stop is always on a frame boundary.
  - A start always begins with the left slot at bit 0.
- **`enable` in RUN**: `enable` = 1 has no effect.
- **Reset**
  - Reset wins over every other event, including mid-frame and during DRAIN.
  - The cycle after `reset` is sampled high, all outputs are 0 and the state is IDLE; there is no drain.
- **Back-to-back start**: when DRAIN completes to IDLE with `enable` already 1 again, IDLE still lasts ≥ 1 cycle before RUN.

## Timing
- All outputs are registered. All pulses are exactly 1 `clk` wide and align with the cycle in which `bck` first reads 1.
- Start latency, with `enable` sampled high in IDLE at cycle 0:
  - RUN at cycle 1.
  - First `bck` rise at cycle 1+BCK_DIV.
  - First `sample_en` at cycle 1+3·BCK_DIV.
- Rate figures:
  - `bck` period = 2·BCK_DIV `clk` cycles.
  - Frame = 2·SLOT_BITS `bck` periods.
  - `sample_en` pulses per frame = 2·WORD_BITS.
- BCK_DIV = 1: `bck` toggles every cycle and `sample_en` is high on alternate cycles.
- Stop latency is at most one frame plus 1 cycle after `enable` falls.

## Test plan
Default parameters for scenarios 1–4: BCK_DIV=2, SLOT_BITS=32, WORD_BITS=24.

1. **Start timing**: `reset` 2 cycles, then `enable`=1 at cycle 0 and held.
   - `busy`=1 at cycle 1.
   - `bck` rises at 3, with no strobe.
   - `sample_en` pulses at 7+4k for k=0..23, with `bit_cnt`=1..24 and `ch`=0.
   - `last_bit` at cycle 99.
   - `lrck`→1 at cycle 129.
2. **Frame counts**: hold `enable` for 4 frames.
   - 48 `sample_en` pulses per frame, 24 each with `ch`=0 and `ch`=1.
   - `frame_start` every 256 cycles.
   - `frame_cnt` = 1 at cycle 257, then 2, 3, 4.
3. **Stop mid-left-slot**: drop `enable` at cycle 50.
   - Right slot still completes.
   - IDLE at cycle 258 with `bck`=`lrck`=0 and `busy`=0.
   - `frame_cnt`=1.
4. **Abort a stop**: drop `enable` at cycle 50, raise it again at cycle 200.
   - No stop occurs.
   - `frame_cnt`=1 at cycle 257, and the second frame is continuous (`frame_start` at cycle 259).
5. **Reset mid-operation**: assert `reset` at cycle 180 for 1 cycle.
   - The next cycle all outputs are 0 and `frame_cnt`=0.
   - A later `enable` restarts with the scenario 1 timing.
6. **Minimum divider**: BCK_DIV=1, WORD_BITS=31, SLOT_BITS=32.
   - `bck` toggles every cycle.
   - 62 strobes per frame and `frame_cnt` increments every 128 cycles.
   - `frame_cnt` wraps 0xFFFF→0 when preloaded by forcing.

Source files
------------

// File: rtl/i2s_frame_ctrl.sv
// rtl/i2s_frame_ctrl.sv - I2S master frame controller
//
// Generates bck/lrck for an I2S receive path from clk. Start and stop
// happen only on stereo-frame boundaries. Per-bit strobes and markers are
// produced in the clk domain, so the receiver never resynchronises bck/lrck.
//
// Ports:
//   clk          system clock (only clock)
//   reset        synchronous, active-high
//   enable       run request, level-sensitive
//   bck          generated bit clock
//   lrck         channel select, 0 = left, 1 = right
//   sample_en    1-cycle pulse on each bck rise carrying a data bit
//   bit_cnt      bit position within the current slot
//   ch           channel of the current sample_en (same as lrck)
//   last_bit     marks the sample_en of the word LSB
//   frame_start  1-cycle pulse on the first bck rise of each left slot
//   frame_cnt    completed frames, wraps at 2^16
//   busy         controller is not idle

module i2s_frame_ctrl #(
    parameter int BCK_DIV   = 4,
    parameter int SLOT_BITS = 32,
    parameter int WORD_BITS = 24,
    localparam int CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          bck,
    output logic          lrck,
    output logic          sample_en,
    output logic [CW-1:0] bit_cnt,
    output logic          ch,
    output logic          last_bit,
    output logic          frame_start,
    output logic [15:0]   frame_cnt,
    output logic          busy
);

    // A divider of 1 still needs a one-bit counter that simply stays at 0.
    localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0] WORD_POS = CW'(WORD_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_q,       state_d;
    logic [DW-1:0] div_cnt_q,     div_cnt_d;
    logic          bck_q,         bck_d;
    logic          lrck_q,        lrck_d;
    logic [CW-1:0] bit_cnt_q,     bit_cnt_d;
    logic          sample_en_q,   sample_en_d;
    logic          last_bit_q,    last_bit_d;
    logic          frame_start_q, frame_start_d;
    logic [15:0]   frame_cnt_q,   frame_cnt_d;
    logic          busy_q,        busy_d;

    logic tick;
    logic rise;
    logic fall;
    logic slot_wrap;
    logic frame_done;

    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        bck_d         = bck_q;
        lrck_d        = lrck_q;
        bit_cnt_d     = bit_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        sample_en_d   = 1'b0;
        last_bit_d    = 1'b0;
        frame_start_d = 1'b0;

        // Edge decode looks at the current bck level: the toggle registered
        // this cycle becomes visible together with the strobes it causes.
        tick       = (state_q != ST_IDLE) && (div_cnt_q == DIV_LAST);
        rise       = tick && !bck_q;
        fall       = tick && bck_q;
        slot_wrap  = (bit_cnt_q == BIT_LAST);
        frame_done = fall && slot_wrap && lrck_q;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bck_d     = 1'b0;
                lrck_d    = 1'b0;
                bit_cnt_d = '0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
                if (tick) begin
                    bck_d = !bck_q;
                end

                // Bit 0 of each slot is the I2S one-bit delay; data bits are
                // 1..WORD_BITS, the remainder of the slot is padding.
                if (rise) begin
                    sample_en_d   = (bit_cnt_q != '0) && (bit_cnt_q <= WORD_POS);
                    last_bit_d    = (bit_cnt_q == WORD_POS);
                    frame_start_d = !lrck_q && (bit_cnt_q == '0);
                end

                if (fall) begin
                    bit_cnt_d = slot_wrap ? '0 : bit_cnt_q + CW'(1);
                    if (slot_wrap) begin
                        lrck_d = !lrck_q;
                    end
                end

                if (frame_done) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end

                if (state_q == ST_RUN) begin
                    if (!enable) begin
                        state_d = ST_DRAIN;
                    end
                end else if (enable) begin
                    // Re-arming during drain keeps the running phase untouched.
                    state_d = ST_RUN;
                end else if (frame_done) begin
                    state_d   = ST_IDLE;
                    div_cnt_d = '0;
                    bck_d     = 1'b0;
                    lrck_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= '0;
            bck_q         <= 1'b0;
            lrck_q        <= 1'b0;
            bit_cnt_q     <= '0;
            sample_en_q   <= 1'b0;
            last_bit_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            bck_q         <= bck_d;
            lrck_q        <= lrck_d;
            bit_cnt_q     <= bit_cnt_d;
            sample_en_q   <= sample_en_d;
            last_bit_q    <= last_bit_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            busy_q        <= busy_d;
        end
    end

    assign bck         = bck_q;
    assign lrck        = lrck_q;
    assign sample_en   = sample_en_q;
    assign bit_cnt     = bit_cnt_q;
    assign ch          = lrck_q;
    assign last_bit    = last_bit_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// tb/tb_i2s_frame_ctrl.sv - self-checking bench for i2s_frame_ctrl

module tb_i2s_frame_ctrl;

    logic clk;
    logic rst0, en0, rst1, en1;

    logic       bck0, lrck0, se0, ch0, last0, fs0, busy0;
    logic [4:0] bc0;
    logic [15:0] fc0;
    logic       bck1, lrck1, se1, ch1, last1, fs1, busy1;
    logic [4:0] bc1;
    logic [15:0] fc1;

    i2s_frame_ctrl #(.BCK_DIV(2), .SLOT_BITS(32), .WORD_BITS(24)) dut0 (
        .clk(clk), .reset(rst0), .enable(en0),
        .bck(bck0), .lrck(lrck0), .sample_en(se0), .bit_cnt(bc0), .ch(ch0),
        .last_bit(last0), .frame_start(fs0), .frame_cnt(fc0), .busy(busy0)
    );

    i2s_frame_ctrl #(.BCK_DIV(1), .SLOT_BITS(32), .WORD_BITS(31)) dut1 (
        .clk(clk), .reset(rst1), .enable(en1),
        .bck(bck1), .lrck(lrck1), .sample_en(se1), .bit_cnt(bc1), .ch(ch1),
        .last_bit(last1), .frame_start(fs1), .frame_cnt(fc1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: derives outputs from the number of clk cycles spent
    // running, using bck period / slot / frame arithmetic.
    int p_div  [2] = '{2, 1};
    int p_slot [2] = '{32, 32};
    int p_word [2] = '{24, 31};

    bit m_run [2];
    bit m_drain [2];
    int m_n [2];
    int m_fc [2];
    bit pre1;

    bit e_bck [2];
    bit e_lrck [2];
    bit e_se [2];
    bit e_last [2];
    bit e_fs [2];
    bit e_busy [2];
    int e_bit [2];
    int e_fc [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit en, rst, pre, stop;
            int tg, f, bp;
            en   = (i == 0) ? en0 : en1;
            rst  = (i == 0) ? rst0 : rst1;
            pre  = (i == 1) && pre1;
            stop = 1'b0;
            e_se[i]   = 1'b0;
            e_last[i] = 1'b0;
            e_fs[i]   = 1'b0;
            if (rst) begin
                m_run[i] = 1'b0; m_drain[i] = 1'b0; m_fc[i] = 0;
                e_bck[i] = 1'b0; e_lrck[i] = 1'b0; e_bit[i] = 0; e_busy[i] = 1'b0;
            end else if (!m_run[i]) begin
                e_bck[i] = 1'b0; e_lrck[i] = 1'b0; e_bit[i] = 0;
                if (en) begin
                    m_run[i] = 1'b1; m_drain[i] = 1'b0; m_n[i] = 0; e_busy[i] = 1'b1;
                end else begin
                    e_busy[i] = 1'b0;
                end
            end else begin
                m_n[i] = m_n[i] + 1;
                tg = m_n[i] / p_div[i];
                f  = tg / 2;
                if (m_n[i] % p_div[i] == 0) begin
                    if (tg % 2 == 1) begin
                        bp = f % p_slot[i];
                        e_se[i]   = (bp >= 1) && (bp <= p_word[i]);
                        e_last[i] = (bp == p_word[i]);
                        e_fs[i]   = ((f / p_slot[i]) % 2 == 0) && (bp == 0);
                    end else if (f % (2 * p_slot[i]) == 0) begin
                        m_fc[i] = (m_fc[i] + 1) % 65536;
                        if (m_drain[i] && !en) stop = 1'b1;
                    end
                end
                m_drain[i] = !en;
                if (stop) begin
                    m_run[i] = 1'b0; m_drain[i] = 1'b0;
                    e_bck[i] = 1'b0; e_lrck[i] = 1'b0; e_bit[i] = 0; e_busy[i] = 1'b0;
                end else begin
                    e_bck[i]  = (tg % 2 == 1);
                    e_lrck[i] = ((f / p_slot[i]) % 2 == 1);
                    e_bit[i]  = f % p_slot[i];
                    e_busy[i] = 1'b1;
                end
            end
            if (pre) m_fc[i] = 65535;
            e_fc[i] = m_fc[i];
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cur = 0;
    bit sel = 1'b0;
    int n_se, n_se_r, n_fs;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t cycle %0d: got %0d expected %0d", name, $time, cur, act, exp);
        end
    endtask

    task automatic cmp_inst(input int i, input logic b, input logic l, input logic s,
                            input logic [4:0] bc, input logic c, input logic la,
                            input logic fs, input logic [15:0] fc, input logic bu);
        string p;
        p = (i == 0) ? "dut0" : "dut1";
        chk({p, ".bck"}, int'(b), int'(e_bck[i]));
        chk({p, ".lrck"}, int'(l), int'(e_lrck[i]));
        chk({p, ".sample_en"}, int'(s), int'(e_se[i]));
        chk({p, ".bit_cnt"}, int'(bc), e_bit[i]);
        chk({p, ".ch"}, int'(c), int'(e_lrck[i]));
        chk({p, ".last_bit"}, int'(la), int'(e_last[i]));
        chk({p, ".frame_start"}, int'(fs), int'(e_fs[i]));
        chk({p, ".frame_cnt"}, int'(fc), e_fc[i]);
        chk({p, ".busy"}, int'(bu), int'(e_busy[i]));
    endtask

    task automatic step();
        @(negedge clk);
        cmp_inst(0, bck0, lrck0, se0, bc0, ch0, last0, fs0, fc0, busy0);
        cmp_inst(1, bck1, lrck1, se1, bc1, ch1, last1, fs1, fc1, busy1);
    endtask

    task automatic to_cycle(input int k);
        logic s, c, f;
        while (cur < k) begin
            step();
            cur++;
            s = sel ? se1 : se0;
            c = sel ? ch1 : ch0;
            f = sel ? fs1 : fs0;
            if (s) begin
                n_se++;
                if (c) n_se_r++;
            end
            if (f) begin
                n_fs++;
                chk("frame_start_phase", sel ? (cur - 2) % 128 : (cur - 3) % 256, 0);
            end
        end
    endtask

    task automatic restart(input int i);
        if (i == 0) begin rst0 = 1'b1; en0 = 1'b0; end
        else        begin rst1 = 1'b1; en1 = 1'b0; end
        step();
        step();
        if (i == 0) begin rst0 = 1'b0; en0 = 1'b1; end
        else        begin rst1 = 1'b0; en1 = 1'b1; end
        cur = 0; n_se = 0; n_se_r = 0; n_fs = 0;
    endtask

    initial begin
        rst0 = 1'b1; en0 = 1'b0; rst1 = 1'b1; en1 = 1'b0; pre1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        step();
        chk("rst_busy", int'(busy0), 0);
        chk("rst_bck", int'(bck0), 0);
        chk("rst_fc", int'(fc0), 0);
        chk("rst_busy1", int'(busy1), 0);
        rst1 = 1'b0;

        // Start timing and frame counts
        restart(0);
        to_cycle(1);    chk("s1_busy", int'(busy0), 1);
        to_cycle(3);    chk("s1_bck_rise", int'(bck0), 1);
                        chk("s1_no_strobe", int'(se0), 0);
                        chk("s1_fs", int'(fs0), 1);
        to_cycle(7);    chk("s1_first_se", int'(se0), 1);
                        chk("s1_first_bit", int'(bc0), 1);
                        chk("s1_ch", int'(ch0), 0);
        to_cycle(99);   chk("s1_last_bit", int'(last0), 1);
                        chk("s1_last_bc", int'(bc0), 24);
        to_cycle(128);  chk("s1_lrck_lo", int'(lrck0), 0);
        to_cycle(129);  chk("s1_lrck_hi", int'(lrck0), 1);
        to_cycle(256);  chk("s2_fc0", int'(fc0), 0);
        to_cycle(257);  chk("s2_fc1", int'(fc0), 1);
        to_cycle(513);  chk("s2_fc2", int'(fc0), 2);
        to_cycle(769);  chk("s2_fc3", int'(fc0), 3);
        to_cycle(1025); chk("s2_fc4", int'(fc0), 4);
                        chk("s2_strobes", n_se, 192);
                        chk("s2_right", n_se_r, 96);
                        chk("s2_frame_starts", n_fs, 4);

        // Stop mid-left-slot
        restart(0);
        to_cycle(50);   en0 = 1'b0;
        to_cycle(258);  chk("s3_busy", int'(busy0), 0);
                        chk("s3_bck", int'(bck0), 0);
                        chk("s3_lrck", int'(lrck0), 0);
                        chk("s3_fc", int'(fc0), 1);
                        chk("s3_strobes", n_se, 48);

        // Abort a stop
        restart(0);
        to_cycle(50);   en0 = 1'b0;
        to_cycle(200);  en0 = 1'b1;
        to_cycle(257);  chk("s4_fc", int'(fc0), 1);
        to_cycle(258);  chk("s4_busy", int'(busy0), 1);
        to_cycle(259);  chk("s4_fs", int'(fs0), 1);

        // Reset mid-operation, then restart with enable held
        restart(0);
        to_cycle(180);  rst0 = 1'b1;
        to_cycle(181);  chk("s5_busy", int'(busy0), 0);
                        chk("s5_bck", int'(bck0), 0);
                        chk("s5_lrck", int'(lrck0), 0);
                        chk("s5_bc", int'(bc0), 0);
                        chk("s5_fc", int'(fc0), 0);
                        chk("s5_se", int'(se0), 0);
        rst0 = 1'b0; cur = 0;
        to_cycle(1);    chk("s5_re_busy", int'(busy0), 1);
        to_cycle(3);    chk("s5_re_bck", int'(bck0), 1);
        to_cycle(7);    chk("s5_re_se", int'(se0), 1);
                        chk("s5_re_bc", int'(bc0), 1);
        en0 = 1'b0;

        // Minimum divider and frame counter wrap
        sel = 1'b1;
        restart(1);
        to_cycle(2);    chk("s6_bck_hi", int'(bck1), 1);
        to_cycle(3);    chk("s6_bck_lo", int'(bck1), 0);
        to_cycle(4);    chk("s6_first_se", int'(se1), 1);
        to_cycle(129);  chk("s6_fc1", int'(fc1), 1);
                        chk("s6_strobes", n_se, 62);
        to_cycle(257);  chk("s6_fc2", int'(fc1), 2);
        to_cycle(260);
        pre1 = 1'b1;
        @(posedge clk);
        #1 force dut1.frame_cnt_q = 16'hFFFF;
        step(); cur++;
        chk("s6_preload", int'(fc1), 65535);
        pre1 = 1'b0;
        @(posedge clk);
        #1 release dut1.frame_cnt_q;
        step(); cur++;
        to_cycle(384);  chk("s6_pre_wrap", int'(fc1), 65535);
        to_cycle(385);  chk("s6_wrap", int'(fc1), 0);
        sel = 1'b0;

        // Randomized enable/reset traffic on both instances
        for (int seg = 0; seg < 40; seg++) begin
            int hold;
            hold = $urandom_range(1, 300);
            en0  = ($urandom_range(0, 9) < 7);
            en1  = ($urandom_range(0, 9) < 7);
            rst0 = ($urandom_range(0, 9) == 0);
            rst1 = ($urandom_range(0, 9) == 0);
            step();
            rst0 = 1'b0;
            rst1 = 1'b0;
            repeat (hold) step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
